// File: rtl/rf_pkg.sv
// Shared definitions for the register-file port sequencer and the register file.
package rf_pkg;

    localparam int RF_WORD_SIZE = 32;
    localparam int RF_REG_COUNT = 32;

    // Architectural zero register: reads as 0, writes are dropped.
    localparam int REG_ZERO = 0;

    // Sequencer states: wait for work, read rs1, read rs2, present operands.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        RESP = 2'd3
    } rf_seq_state_t;

    // Register-index width for a given register count (at least one bit).
    function automatic int rf_aw(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    localparam int RF_AW = rf_aw(RF_REG_COUNT);

endpackage

// File: rtl/rf.sv
// Single-port register file: synchronous write, combinational read on one shared address.
module rf
    import rf_pkg::*;
#(
    parameter  int WORD_SIZE = RF_WORD_SIZE,
    parameter  int REG_COUNT = RF_REG_COUNT,
    localparam int AW        = rf_aw(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem_q [REG_COUNT];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/rf_seq.sv
// Register-file port sequencer: arbitrates writebacks and operand fetches onto the
// single shared register-file port and returns captured operands via valid/ready.
module rf_seq
    import rf_pkg::*;
#(
    parameter  int WORD_SIZE = RF_WORD_SIZE,
    parameter  int REG_COUNT = RF_REG_COUNT,
    localparam int AW        = rf_aw(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // operand fetch request
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AW-1:0]        req_rs1,
    input  logic [AW-1:0]        req_rs2,
    input  logic                 req_two,
    // operand response
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [WORD_SIZE-1:0] op_rs1,
    output logic [WORD_SIZE-1:0] op_rs2,
    // writeback request
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [AW-1:0]        wb_rd,
    input  logic [WORD_SIZE-1:0] wb_data,
    // register-file port
    output logic                 rf_we,
    output logic [AW-1:0]        rf_addr,
    output logic [WORD_SIZE-1:0] rf_wdata,
    input  logic [WORD_SIZE-1:0] rf_rdata
);

    rf_seq_state_t        state_q, state_d;
    logic [AW-1:0]        rs1_q, rs1_d;
    logic [AW-1:0]        rs2_q, rs2_d;
    logic                 two_q, two_d;
    logic [WORD_SIZE-1:0] op_rs1_q, op_rs1_d;
    logic [WORD_SIZE-1:0] op_rs2_q, op_rs2_d;

    logic                 req_ready_c;
    logic                 wb_ready_c;
    logic                 rf_we_c;
    logic [AW-1:0]        rf_addr_c;

    // x0 always reads as zero regardless of what the file returns.
    function automatic logic [WORD_SIZE-1:0] read_val(input logic [AW-1:0]        idx,
                                                       input logic [WORD_SIZE-1:0] data);
        return (idx == AW'(REG_ZERO)) ? '0 : data;
    endfunction

    // State, latched request and captured operands; reset drops any in-flight fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            two_q    <= 1'b0;
            op_rs1_q <= '0;
            op_rs2_q <= '0;
        end else begin
            state_q  <= state_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            two_q    <= two_d;
            op_rs1_q <= op_rs1_d;
            op_rs2_q <= op_rs2_d;
        end
    end

    // Next-state and port control; writeback wins over fetch in IDLE.
    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        two_d       = two_q;
        op_rs1_d    = op_rs1_q;
        op_rs2_d    = op_rs2_q;
        req_ready_c = 1'b0;
        wb_ready_c  = 1'b0;
        rf_we_c     = 1'b0;
        rf_addr_c   = '0;

        unique case (state_q)
            IDLE: begin
                wb_ready_c  = 1'b1;
                req_ready_c = !wb_valid;
                if (wb_valid) begin
                    // A write to x0 is accepted but suppressed at the file.
                    rf_addr_c = wb_rd;
                    rf_we_c   = (wb_rd != AW'(REG_ZERO));
                end else if (req_valid) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    two_d   = req_two;
                    state_d = RD1;
                end
            end
            RD1: begin
                rf_addr_c = rs1_q;
                op_rs1_d  = read_val(rs1_q, rf_rdata);
                if (two_q) begin
                    state_d = RD2;
                end else begin
                    op_rs2_d = '0;
                    state_d  = RESP;
                end
            end
            RD2: begin
                rf_addr_c = rs2_q;
                op_rs2_d  = read_val(rs2_q, rf_rdata);
                state_d   = RESP;
            end
            RESP: begin
                if (op_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and port outputs are forced low while reset is asserted.
    assign req_ready = rst_n & req_ready_c;
    assign wb_ready  = rst_n & wb_ready_c;
    assign rf_we     = rst_n & rf_we_c;
    assign rf_addr   = rst_n ? rf_addr_c : '0;
    assign rf_wdata  = wb_data;

    assign op_valid  = (state_q == RESP);
    assign op_rs1    = op_rs1_q;
    assign op_rs2    = op_rs2_q;

endmodule

// File: tb/tb_rf_seq.sv
// Directed self-checking bench for rf_seq paired with the rf register file.
module tb_rf_seq;
    import rf_pkg::*;

    localparam int W  = 32;
    localparam int AW = rf_aw(32);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_rs1 = '0;
    logic [AW-1:0] req_rs2 = '0;
    logic          req_two = 1'b0;
    logic          op_valid;
    logic          op_ready = 1'b0;
    logic [W-1:0]  op_rs1;
    logic [W-1:0]  op_rs2;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [AW-1:0] wb_rd = '0;
    logic [W-1:0]  wb_data = '0;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [W-1:0]  rf_wdata;
    logic [W-1:0]  rf_rdata;

    int compared = 0;
    int mismatched = 0;

    rf_seq #(.WORD_SIZE(W), .REG_COUNT(32)) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_two   (req_two),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_rs1    (op_rs1),
        .op_rs2    (op_rs2),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata)
    );

    rf #(.WORD_SIZE(W), .REG_COUNT(32)) u_rf (
        .clk   (clk),
        .we    (rf_we),
        .addr  (rf_addr),
        .wdata (rf_wdata),
        .rdata (rf_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One writeback accepted from IDLE.
    task automatic do_wb(input string tag, input logic [AW-1:0] rd, input logic [W-1:0] data);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        #1;
        chk({tag, "_wb_ready"}, 32'(wb_ready), 32'd1);
        chk({tag, "_rf_we"}, 32'(rf_we), (rd != 0) ? 32'd1 : 32'd0);
        chk({tag, "_rf_addr"}, 32'(rf_addr), 32'(rd));
        chk({tag, "_rf_wdata"}, rf_wdata, data);
        @(posedge clk);
        #1 wb_valid = 1'b0;
    endtask

    // Complete fetch from IDLE, checking per-cycle address, latency and operands.
    task automatic run_fetch(input string tag, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                             input logic two, input logic [W-1:0] exp1, input logic [W-1:0] exp2);
        @(negedge clk);
        req_valid = 1'b1;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_two   = two;
        #1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_rd1_addr"}, 32'(rf_addr), 32'(rs1));
        chk({tag, "_rd1_opv"}, 32'(op_valid), 32'd0);
        chk({tag, "_rd1_reqrdy"}, 32'(req_ready), 32'd0);
        if (two) begin
            @(negedge clk);
            chk({tag, "_rd2_addr"}, 32'(rf_addr), 32'(rs2));
            chk({tag, "_rd2_opv"}, 32'(op_valid), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_opv"}, 32'(op_valid), 32'd1);
        chk({tag, "_op_rs1"}, op_rs1, exp1);
        chk({tag, "_op_rs2"}, op_rs2, exp2);
        op_ready = 1'b1;
        @(posedge clk);
        #1 op_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_opv_drop"}, 32'(op_valid), 32'd0);
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_opv", 32'(op_valid), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_addr", 32'(rf_addr), 32'd0);
        chk("rst_op_rs1", op_rs1, 32'd0);
        chk("rst_op_rs2", op_rs2, 32'd0);
        chk("rst_reqrdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_reqrdy", 32'(req_ready), 32'd1);
        chk("post_rst_wbrdy", 32'(wb_ready), 32'd1);

        // writeback then two-operand fetch including x0
        do_wb("wb5", 5'd5, 32'hDEADBEEF);
        run_fetch("f5_0", 5'd5, 5'd0, 1'b1, 32'hDEADBEEF, 32'h0);

        // write to x0 is suppressed; x0 reads 0
        do_wb("wb0", 5'd0, 32'h1234);
        run_fetch("f0", 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);

        // simultaneous writeback and fetch: writeback first, fetch waits one cycle
        @(negedge clk);
        wb_valid  = 1'b1;
        wb_rd     = 5'd7;
        wb_data   = 32'hA5A5A5A5;
        req_valid = 1'b1;
        req_rs1   = 5'd7;
        req_rs2   = 5'd0;
        req_two   = 1'b0;
        #1;
        chk("sim_reqrdy", 32'(req_ready), 32'd0);
        chk("sim_wbrdy", 32'(wb_ready), 32'd1);
        chk("sim_we", 32'(rf_we), 32'd1);
        chk("sim_addr", 32'(rf_addr), 32'd7);
        @(posedge clk);
        #1 wb_valid = 1'b0;
        req_valid = 1'b0;
        run_fetch("sim_f7", 5'd7, 5'd0, 1'b0, 32'hA5A5A5A5, 32'h0);

        // two-operand fetch leaves op_rs2 nonzero, one-operand fetch must clear it
        run_fetch("f5_7", 5'd5, 5'd7, 1'b1, 32'hDEADBEEF, 32'hA5A5A5A5);
        do_wb("wb3", 5'd3, 32'h11);
        run_fetch("f3", 5'd3, 5'd0, 1'b0, 32'h11, 32'h0);

        // backpressure in RESP with a pending writeback
        @(negedge clk);
        req_valid = 1'b1;
        req_rs1   = 5'd3;
        req_rs2   = 5'd5;
        req_two   = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        wb_data  = 32'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_wbrdy", 32'(wb_ready), 32'd0);
            chk("hold_we", 32'(rf_we), 32'd0);
            chk("hold_opv", 32'(op_valid), 32'd1);
            chk("hold_op_rs1", op_rs1, 32'h11);
            chk("hold_op_rs2", op_rs2, 32'hDEADBEEF);
            @(negedge clk);
        end
        op_ready = 1'b1;
        @(posedge clk);
        #1 op_ready = 1'b0;
        chk("hold_idle_wbrdy", 32'(wb_ready), 32'd1);
        chk("hold_idle_reqrdy", 32'(req_ready), 32'd0);
        chk("hold_idle_we", 32'(rf_we), 32'd1);
        chk("hold_idle_addr", 32'(rf_addr), 32'd9);
        @(posedge clk);
        #1 wb_valid = 1'b0;
        run_fetch("f9", 5'd9, 5'd0, 1'b0, 32'h99, 32'h0);

        // asynchronous reset during RD2
        @(negedge clk);
        req_valid = 1'b1;
        req_rs1   = 5'd5;
        req_rs2   = 5'd7;
        req_two   = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd2_addr", 32'(rf_addr), 32'd7);
        chk("rd2_op_rs1", op_rs1, 32'hDEADBEEF);
        #2;
        rst_n    = 1'b0;
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'h0;
        #1;
        chk("arst_opv", 32'(op_valid), 32'd0);
        chk("arst_op_rs1", op_rs1, 32'd0);
        chk("arst_op_rs2", op_rs2, 32'd0);
        chk("arst_we", 32'(rf_we), 32'd0);
        chk("arst_addr", 32'(rf_addr), 32'd0);
        chk("arst_reqrdy", 32'(req_ready), 32'd0);
        chk("arst_wbrdy", 32'(wb_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_edge_we", 32'(rf_we), 32'd0);
        wb_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_rel_opv", 32'(op_valid), 32'd0);
        chk("arst_rel_reqrdy", 32'(req_ready), 32'd1);
        run_fetch("f_after_rst", 5'd5, 5'd7, 1'b1, 32'hDEADBEEF, 32'hA5A5A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
